// File: rtl/cordic_sched.sv
// Two-port request scheduler for a fixed-latency 8-bit CORDIC pipeline.
// A shadow {vld,tag} shift register tracks each entry's owner.
module cordic_sched #(
    parameter int LATENCY = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_x,
    input  logic [7:0] req0_y,
    input  logic [7:0] req0_deg,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_x,
    input  logic [7:0] req1_y,
    input  logic [7:0] req1_deg,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_x,
    output logic [7:0] rsp0_y,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_x,
    output logic [7:0] rsp1_y,
    output logic       cor_enable,
    output logic [7:0] cor_xin,
    output logic [7:0] cor_yin,
    output logic [7:0] cor_degrees,
    input  logic [7:0] cor_xp,
    input  logic [7:0] cor_yp,
    output logic       busy,
    output logic [3:0] inflight
);

    localparam logic signed [7:0] DMAX = 8'sd90;
    localparam logic signed [7:0] DMIN = -8'sd90;

    logic [LATENCY:1] vld;
    logic [LATENCY:1] tag;
    logic             last;
    logic [3:0]       cnt;

    logic       tail_vld;
    logic       tail_tag;
    logic       tail_ready;
    logic       advance;
    logic       gnt_vld;
    logic       gnt;
    logic       issue;
    logic       complete;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic [7:0] sel_d;
    logic [7:0] clamp_d;

    assign tail_vld   = vld[LATENCY];
    assign tail_tag   = tag[LATENCY];
    assign tail_ready = tail_tag ? rsp1_ready : rsp0_ready;

    // Whole pipeline freezes while the tail waits: delivery stays in order.
    assign advance    = ~reset & (~tail_vld | tail_ready);
    assign cor_enable = advance;
    assign complete   = advance & tail_vld;

    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt     = 1'b0;
        if (req0_valid & req1_valid)
            gnt = ~last;
        else
            gnt = req1_valid;
    end

    assign issue      = advance & gnt_vld;
    assign req0_ready = issue & ~gnt;
    assign req1_ready = issue & gnt;

    assign sel_x = gnt ? req1_x   : req0_x;
    assign sel_y = gnt ? req1_y   : req0_y;
    assign sel_d = gnt ? req1_deg : req0_deg;

    always_comb begin
        clamp_d = sel_d;
        if ($signed(sel_d) > DMAX)
            clamp_d = DMAX;
        else if ($signed(sel_d) < DMIN)
            clamp_d = DMIN;
    end

    assign cor_xin     = issue ? sel_x   : 8'd0;
    assign cor_yin     = issue ? sel_y   : 8'd0;
    assign cor_degrees = issue ? clamp_d : 8'd0;

    assign rsp0_valid = tail_vld & ~tail_tag;
    assign rsp1_valid = tail_vld & tail_tag;
    assign rsp0_x     = rsp0_valid ? cor_xp : 8'd0;
    assign rsp0_y     = rsp0_valid ? cor_yp : 8'd0;
    assign rsp1_x     = rsp1_valid ? cor_xp : 8'd0;
    assign rsp1_y     = rsp1_valid ? cor_yp : 8'd0;

    assign inflight = cnt;
    assign busy     = (cnt != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            tag  <= '0;
            last <= 1'b1;
            cnt  <= 4'd0;
        end else begin
            if (advance) begin
                vld <= {vld[LATENCY-1:1], issue};
                tag <= {tag[LATENCY-1:1], issue & gnt};
            end
            if (issue)
                last <= gnt;
            if (issue & ~complete)
                cnt <= cnt + 4'd1;
            else if (~issue & complete)
                cnt <= cnt - 4'd1;
        end
    end

endmodule
